// File: rtl/chunk_subtractor.sv
// Multi-cycle unsigned subtractor: A - B computed as A + ~B + 1, one CHUNK-bit
// slice per clock, least-significant slice first, with a single rippled carry.
`timescale 1ns/1ps
module chunk_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] chunkMask = {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}};
    localparam logic [IDXW-1:0]  lastIdx   = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic [IDXW-1:0]   idx;
    logic              carry;

    logic [CHUNK-1:0]  aChunk;
    logic [CHUNK-1:0]  bChunk;
    logic [CHUNK:0]    chunkSum;
    logic [WIDTH-1:0]  diffNext;
    int                base;

    // Five-bit slice add; the top bit is the carry into the next slice.
    function automatic logic [CHUNK:0] chunkAdd(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             cin);
        return {1'b0, x} + {1'b0, y} + (CHUNK+1)'(cin);
    endfunction

    always_comb begin
        base     = int'(idx) * CHUNK;
        aChunk   = CHUNK'(opA >> base);
        bChunk   = CHUNK'(opB >> base);
        chunkSum = chunkAdd(aChunk, bChunk, carry);
        diffNext = (diff & ~(chunkMask << base))
                 | (WIDTH'(chunkSum[CHUNK-1:0]) << base);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            opA       <= '0;
            opB       <= '0;
            idx       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opA      <= a;
                        opB      <= ~b;
                        carry    <= 1'b1;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff  <= diffNext;
                    carry <= chunkSum[CHUNK];
                    if (idx == lastIdx) begin
                        // Final carry of A + ~B + 1 is the inverted borrow.
                        idx       <= '0;
                        out_valid <= 1'b1;
                        borrow    <= ~chunkSum[CHUNK];
                        zero      <= (diffNext == '0);
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_subtractor.sv
// Bench for chunk_subtractor: directed vector table, corner sequences and
// randomized operations checked against plain unsigned arithmetic.
`timescale 1ns/1ps
module tb_chunk_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int acceptCyc = 0;

    chunk_subtractor #(.WIDTH(32), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] expDiff;
        logic        expBorrow;
        logic        expZero;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers one operation, waits for its result, optionally stalls the
    // consumer for 'hold' cycles, then drains it.
    task automatic runOp(input logic [31:0] va, input logic [31:0] vb, input int hold,
                         output logic [31:0] gd, output logic gb, output logic gz,
                         output int lat);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        out_ready = (hold == 0);
        check("in_ready_before_accept", 64'(in_ready), 64'(1));
        tick;
        acceptCyc = cyc;
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
        gd = diff;
        gb = borrow;
        gz = zero;
        for (int i = 0; i < hold; i++) begin
            check("hold_diff_stable", 64'(diff), 64'(gd));
            check("hold_borrow_stable", 64'(borrow), 64'(gb));
            check("hold_zero_stable", 64'(zero), 64'(gz));
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready_low", 64'(in_ready), 64'(0));
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("drain_out_valid_low", 64'(out_valid), 64'(0));
        check("drain_in_ready_high", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd;
        logic        gb;
        logic        gz;
        int          lat;
        int          firstAccept;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] refDiff;
        int          pulse;

        vecs[0] = '{32'd5,         32'd3,         32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0,         32'h0,         32'h0000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{32'h0,         32'h1,         32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_diff", 64'(diff), 64'(0));
        check("reset_borrow", 64'(borrow), 64'(0));
        check("reset_zero", 64'(zero), 64'(0));
        rst = 1'b0;
        tick;

        for (int i = 0; i < 7; i++) begin
            runOp(vecs[i].va, vecs[i].vb, 0, gd, gb, gz, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(8));
            check($sformatf("vec%0d_diff", i), 64'(gd), 64'(vecs[i].expDiff));
            check($sformatf("vec%0d_borrow", i), 64'(gb), 64'(vecs[i].expBorrow));
            check($sformatf("vec%0d_zero", i), 64'(gz), 64'(vecs[i].expZero));
        end

        // Back-to-back throughput with out_ready held high.
        runOp(32'd100, 32'd1, 0, gd, gb, gz, lat);
        firstAccept = acceptCyc;
        runOp(32'd7, 32'd9, 0, gd, gb, gz, lat);
        check("throughput_period", 64'(acceptCyc - firstAccept), 64'(10));
        check("b2b_diff", 64'(gd), 64'(32'hFFFF_FFFE));
        check("b2b_borrow", 64'(gb), 64'(1));

        // Backpressure: stall 5 cycles, stray in_valid ignored, then a fresh op.
        runOp(32'hDEAD_BEEF, 32'h0000_BEEF, 5, gd, gb, gz, lat);
        check("bp_latency", 64'(lat), 64'(8));
        check("bp_diff", 64'(gd), 64'(32'hDEAD_0000));
        check("bp_borrow", 64'(gb), 64'(0));
        runOp(32'd1000, 32'd1, 0, gd, gb, gz, lat);
        check("after_bp_diff", 64'(gd), 64'(32'd999));
        check("after_bp_zero", 64'(gz), 64'(0));

        // Asynchronous reset during RUN discards the partial result.
        in_valid  = 1'b1;
        a         = 32'h1234_5678;
        b         = 32'h0000_0001;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'(0));
        check("midrun_rst_in_ready", 64'(in_ready), 64'(1));
        check("midrun_rst_diff", 64'(diff), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) pulse++;
            tick;
        end
        check("midrun_rst_no_pulse", 64'(pulse), 64'(0));
        runOp(32'd10, 32'd10, 0, gd, gb, gz, lat);
        check("after_rst_latency", 64'(lat), 64'(8));
        check("after_rst_diff", 64'(gd), 64'(0));
        check("after_rst_borrow", 64'(gb), 64'(0));
        check("after_rst_zero", 64'(gz), 64'(1));

        // Randomized operations against plain unsigned arithmetic.
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = (n % 16 == 0) ? ra : 32'($urandom);
            if (n % 7 == 0) rb = ra + 32'($urandom_range(0, 3));
            refDiff = ra - rb;
            runOp(ra, rb, $urandom_range(0, 3), gd, gb, gz, lat);
            check($sformatf("rand%0d_latency", n), 64'(lat), 64'(8));
            check($sformatf("rand%0d_diff a=%0h b=%0h", n, ra, rb), 64'(gd), 64'(refDiff));
            check($sformatf("rand%0d_borrow", n), 64'(gb), 64'(ra < rb));
            check($sformatf("rand%0d_zero", n), 64'(gz), 64'(ra == rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
